// File: rtl/set_rd.sv
// -----------------------------------------------------------------------------
// set_rd -- settings window read-back responder
//
// Answers CPU read cycles on the settings chip-select. A registered request
// snapshots either the configuration word (slow-device enables and timeout, in
// the same bit layout the write side decodes from the address) or an ID/status
// word into D. The block then drives DOE, waits WAIT_CYCLES clocks and asserts
// nDTACK until the bus cycle ends.
//
// Build option: define SET_RD_ID_EN to enable the ID word (DEV_ID plus a
// "settings written since last ID read" Dirty flag), selected by A = 1.
// Without it, A is ignored and every read returns the configuration word.
//
// Parameters:
//   WAIT_CYCLES  wait states between data drive and DTACK (0..15)
//   DEV_ID       8-bit identifier in the ID word
// Ports:
//   CLK           system clock, rising edge
//   POR           synchronous active-high reset
//   BACT          bus cycle active
//   SetCSRD       settings read chip-select (qualified by BACT)
//   SetCSWR       settings write chip-select (feeds the Dirty flag only)
//   A             word select: 0 = config word, 1 = ID word
//   SlowTimeout   current timeout setting
//   Slow*         current slow-device enables
//   D             read data
//   DOE           data output enable, active-high
//   nDTACK        data acknowledge, active-low
// -----------------------------------------------------------------------------
module set_rd #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  DEV_ID      = 8'h5E
) (
    input  logic        CLK,
    input  logic        POR,
    input  logic        BACT,
    input  logic        SetCSRD,
    input  logic        SetCSWR,
    input  logic        A,
    input  logic [3:0]  SlowTimeout,
    input  logic        SlowIACK,
    input  logic        SlowVIA,
    input  logic        SlowIWM,
    input  logic        SlowSCC,
    input  logic        SlowSCSI,
    input  logic        SlowSnd,
    input  logic        SlowClockGate,
    output logic [15:0] D,
    output logic        DOE,
    output logic        nDTACK
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]  state;
    logic [3:0]  Cnt;
    logic        ReqR;
    logic        WrR;
    logic        Busy;
    logic        accept;
    logic [15:0] cfgWord;
    logic [15:0] selWord;

    // Configuration word, laid out exactly as the write side decodes it
    always_comb begin
        cfgWord = {4'h0, SlowTimeout, SlowIACK, SlowVIA, SlowIWM, SlowSCC,
                   SlowSCSI, SlowSnd, SlowClockGate, 1'b0};
    end

    // Busy blocks a request left over from the cycle just finished
    assign accept = (state == S_IDLE) && ReqR && !Busy;

`ifdef SET_RD_ID_EN
    logic Dirty;

    // Word selection between config and ID/status
    always_comb begin
        if (A) begin
            selWord = {DEV_ID, 7'h00, Dirty};
        end else begin
            selWord = cfgWord;
        end
    end

    // Dirty flag: set by any settings write, cleared by an ID snapshot; set wins
    always_ff @(posedge CLK) begin
        if (POR) begin
            Dirty <= 1'b0;
        end else if (WrR) begin
            Dirty <= 1'b1;
        end else if (accept && A) begin
            Dirty <= 1'b0;
        end else begin
            Dirty <= Dirty;
        end
    end
`else
    logic unusedIdInputs;

    // Only the config word exists in this build
    always_comb begin
        selWord = cfgWord;
    end

    assign unusedIdInputs = ^{A, WrR, DEV_ID};
`endif

    // Request registration, re-arm latch and read-cycle state machine
    always_ff @(posedge CLK) begin
        if (POR) begin
            state  <= S_IDLE;
            D      <= 16'h0000;
            DOE    <= 1'b0;
            nDTACK <= 1'b1;
            Cnt    <= 4'd0;
            ReqR   <= 1'b0;
            WrR    <= 1'b0;
            Busy   <= 1'b0;
        end else begin
            ReqR <= BACT && SetCSRD;
            WrR  <= BACT && SetCSWR;

            if (accept) begin
                Busy <= 1'b1;
            end else if (!BACT) begin
                Busy <= 1'b0;
            end else begin
                Busy <= Busy;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        D      <= selWord;
                        DOE    <= 1'b1;
                        nDTACK <= 1'b1;
                        Cnt    <= WAIT_LOAD;
                        // With no wait states, DTACK is still given one clock
                        // after the data, asserted from the ACK state itself.
                        state  <= (WAIT_LOAD == 4'd0) ? S_ACK : S_WAIT;
                    end else begin
                        DOE    <= 1'b0;
                        nDTACK <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!BACT) begin
                        state  <= S_IDLE;
                        DOE    <= 1'b0;
                        nDTACK <= 1'b1;
                    end else if (Cnt <= 4'd1) begin
                        state  <= S_ACK;
                        nDTACK <= 1'b0;
                    end else begin
                        Cnt <= Cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    if (!BACT) begin
                        state  <= S_IDLE;
                        DOE    <= 1'b0;
                        nDTACK <= 1'b1;
                    end else begin
                        DOE    <= 1'b1;
                        nDTACK <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    DOE    <= 1'b0;
                    nDTACK <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/set_rd.md
# set_rd

Read-back responder for the settings register window. It answers CPU read cycles to the settings chip-select by returning the current slow-device and timeout configuration, in the same bit layout the write side decodes from the address. It also returns an optional ID/status word. It sits beside the settings write block on the CPU bus and owns data-output enable and DTACK for settings reads.

## Interface
- WAIT_CYCLES, default 2: wait states inserted between data drive and DTACK assertion (0–15).
- DEV_ID, default 8'h5E: 8-bit identifier returned in the ID word.
- CLK  in  1  system clock; all logic on its rising edge.
- POR  in  1  reset, synchronous, active-high.
- BACT  in  1  bus cycle active.
- SetCSRD  in  1  settings read chip-select, qualified by BACT.
- SetCSWR  in  1  settings write chip-select; used only for the dirty flag.
- A  in  1  word select, A[1]: 0 = config word, 1 = ID word.
- SlowTimeout  in  4  current timeout setting.
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd, SlowClockGate  in  1 each  current settings.
- D  out  16  read data.
- DOE  out  1  data output enable, active-high.
- nDTACK  out  1  data acknowledge, active-low.

## Operation
- Request registration: ReqR <= BACT && SetCSRD; WrR <= BACT && SetCSWR. Both are registered every cycle.
- Config word: D[15:12]=0, D[11:8]=SlowTimeout, D[7]=SlowIACK, D[6]=SlowVIA, D[5]=SlowIWM, D[4]=SlowSCC, D[3]=SlowSCSI, D[2]=SlowSnd, D[1]=SlowClockGate, D[0]=0.
  - Software writes the value back by adding it to the write-window base.
- ID word: D[15:8]=DEV_ID, D[7:1]=0, D[0]=Dirty.
- Dirty flag:
  - Set when WrR=1.
  - Cleared when an ID word is snapshotted.
  - If set and clear occur in the same cycle, set wins.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: if ReqR, snapshot the selected word into D (A[1] as sampled in that cycle) and assert DOE. Load Cnt=WAIT_CYCLES. Next state is WAIT, or ACK directly if WAIT_CYCLES=0.
  - WAIT: if BACT=0, go to IDLE (abort). Else if Cnt==1, go to ACK. Else decrement Cnt.
  - ACK: nDTACK=0, DOE=1, D held. When BACT=0, go to IDLE; nDTACK and DOE deassert on that same edge.
- D is held stable from snapshot until return to IDLE. Setting changes during a cycle do not alter D.
- A new request is accepted only from IDLE. A ReqR still high on the IDLE entry edge is ignored until BACT has been low for at least one cycle (re-arm latch Busy).
- Cnt is 4 bits and never wraps below 0.

## Timing
- Reset (POR=1 at an edge): state=IDLE, D=16'h0000, DOE=0, nDTACK=1, Cnt=0, Dirty=0, ReqR=WrR=0, Busy=0. Reset wins over any in-flight cycle; outputs release on that edge.
- Latency, edge-numbered from the first edge sampling BACT&&SetCSRD=1 (edge 0):
  - ReqR=1 after edge 0.
  - DOE=1 and D valid after edge 1.
  - nDTACK=0 after edge 1+WAIT_CYCLES (WAIT_CYCLES≥1), or after edge 2 for WAIT_CYCLES=0.
- Release: first edge sampling BACT=0 while in ACK returns to IDLE, with nDTACK=1 and DOE=0 after that edge.
- Abort: BACT=0 sampled in WAIT goes to IDLE next edge; nDTACK is never asserted.
- SetCSRD and SetCSWR both high: read proceeds normally and Dirty sets.

## Configuration
- SET_RD_ID_EN defined: ID word and Dirty flag are implemented as above.
- SET_RD_ID_EN undefined: A[1] is ignored and every read returns the config word. Dirty logic and DEV_ID are removed. Timing is unchanged.

## Test plan
- Reset: POR=1 for 2 cycles mid-ACK -> D=0, DOE=0, nDTACK=1, state IDLE next edge.
- Config read, WAIT_CYCLES=2, SlowTimeout=4'hA, SlowVIA=1, SlowClockGate=1, all other settings 0 -> D=16'h0A42. DOE rises after edge 1; nDTACK falls after edge 3; both release one edge after BACT drops.
- ID read with SET_RD_ID_EN, after one write -> D=16'h5E01. A second ID read -> D=16'h5E00. Write coinciding with the first read's snapshot -> second read still 16'h5E01.
- WAIT_CYCLES=0 -> nDTACK low after edge 2. Without SET_RD_ID_EN, an A[1]=1 read returns the config word.
- Abort: BACT drops in WAIT -> IDLE, nDTACK stays 1 throughout, DOE=0 next edge. The next read completes normally.
- Back-to-back: BACT held high across ACK exit -> no second acknowledge until BACT low for one cycle. Settings toggled during ACK -> D unchanged.
